// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: opcodes, fetch FSM states, and the
// prefetch queue entry layout (instruction word plus its PC+1).
package mips_pipe_pkg;

    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } pq_entry_t;

endpackage

// File: rtl/mips_prefetch_queue_if.sv
// Bus bundle of the prefetch queue: instruction-memory port, redirect
// input and the head handshake towards IF/ID.
//   master: the queue (drives imem_req/addr, out_*, halted)
//   slave : its environment (drives imem_rdata, redirect*, out_ready)
interface mips_prefetch_queue_if #(
    parameter int AW = 10
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_ir;
    logic [31:0]   out_npc;
    logic          out_ready;
    logic          halted;

    modport master (
        output imem_req, imem_addr, out_valid, out_ir, out_npc, halted,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_ir, out_npc, halted,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/mips_prefetch_queue_fifo.sv
// prefetch_fifo: DEPTH x 64-bit storage with read/write pointers.
// Ports: clk1, rst (sync, high), i_clr (flush), i_push/i_wdata,
// i_pop, o_rdata (head), o_count, o_empty. Push accepted when full
// if a pop happens in the same cycle.
module prefetch_fifo
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  pq_entry_t              i_wdata,
    input  logic                   i_pop,
    output pq_entry_t              o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

    pq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_rd = i_pop && (r_count != '0);
    assign w_wr = i_push && ((r_count != L_DEPTH) || w_rd);

    always_ff @(posedge clk1) begin
        if (rst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (w_wr && !i_clr && !rst) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/mips_prefetch_queue.sv
// MIPS instruction prefetch queue: issues one fetch per cycle while
// room remains (queued + in-flight < DEPTH), buffers {ir, pc+1}, stops
// fetching once an HLT word is enqueued, flushes on redirect.
// Ports: clk1, rst (sync, high), bus (mips_prefetch_queue_if.master).
// Option: define PREFETCH_BYPASS_EN to forward a response straight to
// the head when the queue is empty (1-cycle latency instead of 2).
module mips_prefetch_queue
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk1,
    input  logic                   rst,
    mips_prefetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    fetch_state_e  r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_empty;
    pq_entry_t     w_head;
    pq_entry_t     w_wentry;
    logic          w_arrive;
    logic          w_hlt_in;
    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [31:0]   w_ir;
    logic [31:0]   w_npc;

    // A response is dropped if redirect or reset lands on its arrival.
    assign w_arrive = r_inflight && !bus.redirect && !rst;
    assign w_hlt_in = w_arrive && (bus.imem_rdata[31:26] == OP_HLT);

    assign w_wentry.ir  = bus.imem_rdata;
    assign w_wentry.npc = r_req_pc + 32'd1;

    // In-flight word counts against capacity so a push never overflows.
    assign w_occ = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

    // An arriving HLT blocks the request issued alongside it.
    assign w_req = !rst && !bus.redirect && (r_state == FETCH)
                   && !w_hlt_in && (w_occ < L_DEPTH);

`ifdef PREFETCH_BYPASS_EN
    logic w_byp;
    assign w_byp   = w_empty && w_arrive;
    assign w_valid = !w_empty || w_arrive;
    assign w_ir    = w_empty ? bus.imem_rdata : w_head.ir;
    assign w_npc   = w_empty ? w_wentry.npc   : w_head.npc;
    // A bypassed word taken this cycle never enters storage.
    assign w_push  = w_arrive && !(w_byp && bus.out_ready);
`else
    assign w_valid = !w_empty;
    assign w_ir    = w_head.ir;
    assign w_npc   = w_head.npc;
    assign w_push  = w_arrive;
`endif

    assign bus.out_valid = w_valid && !bus.redirect && !rst;
    assign bus.out_ir    = rst ? 32'd0 : w_ir;
    assign bus.out_npc   = rst ? 32'd0 : w_npc;
    assign w_pop         = bus.out_valid && bus.out_ready && !w_empty;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc[AW-1:0];
    assign bus.halted    = (r_state == HALTED) && !rst;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state    <= FETCH;
            r_fetch_pc <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_fetch_pc;
            end
            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
            end else if (w_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd1;
            end
            // HALTED is left only through reset, redirect included.
            if (w_hlt_in) begin
                r_state <= HALTED;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1    (clk1),
        .rst     (rst),
        .i_clr   (bus.redirect),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_mips_prefetch_queue.sv
// Directed bench for mips_prefetch_queue: reset, streaming, backpressure,
// redirect flush, address wrap, HLT stop and mid-run reset.
module tb_mips_prefetch_queue;
    import mips_pipe_pkg::*;

`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk1;
    logic        rst;
    logic [31:0] mem [0:1023];
    int          checks   = 0;
    int          failures = 0;
    int          req_cnt  = 0;
    int          first;

    mips_prefetch_queue_if #(.AW(10)) bus ();

    mips_prefetch_queue #(
        .DEPTH (4),
        .AW    (10)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Instruction memory: word valid the cycle after the request.
    always @(posedge clk1) begin
        if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
        if (rst)               req_cnt <= 0;
        else if (bus.imem_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.redirect = 1'b0;
        repeat (2) @(negedge clk1);
        rst = 1'b0;
    endtask

    // Pops n words (out_ready must be 1), expecting npc0, npc0+1, ...
    // and the matching memory word; first = cycle of the first pop.
    task automatic collect(input string tag, input int n,
                           input logic [31:0] npc0, output int fst);
        int          k;
        logic [31:0] e;
        logic [31:0] idx;
        k   = 0;
        fst = -1;
        for (int c = 0; c < 40 && k < n; c++) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (fst < 0) fst = c;
                e   = npc0 + 32'(k);
                idx = e - 32'd1;
                chk({tag, "_npc"}, bus.out_npc, e);
                chk({tag, "_ir"}, bus.out_ir, mem[idx[9:0]]);
                k++;
            end
            @(negedge clk1);
        end
        chk({tag, "_cnt"}, 32'(k), 32'(n));
    endtask

    initial begin
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = {6'b000000, 26'(i)};

        // Reset state
        repeat (2) @(negedge clk1);
        #1;
        chk("rst_req",    32'(bus.imem_req),  32'd0);
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted),    32'd0);
        chk("rst_ir",     bus.out_ir,         32'd0);
        chk("rst_npc",    bus.out_npc,        32'd0);

        // Streaming from PC 0
        @(negedge clk1);
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("c0_req",  32'(bus.imem_req),  32'd1);
        chk("c0_addr", 32'(bus.imem_addr), 32'd0);
        collect("seq", 4, 32'd1, first);
        chk("seq_lat", 32'(first), 32'(LAT));
        chk("seq_halted", 32'(bus.halted), 32'd0);

        // Reset mid-stream discards queue and in-flight word
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_req",   32'(bus.imem_req),  32'd0);
        @(negedge clk1);
        rst = 1'b0;
        #1;
        chk("mrst_post_valid", 32'(bus.out_valid), 32'd0);
        collect("mrst", 2, 32'd1, first);
        chk("mrst_lat", 32'(first), 32'(LAT));

        // Backpressure: exactly DEPTH requests, then no loss
        bus.out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk1);
        #1;
        chk("bp_reqs",  32'(req_cnt),         32'd4);
        chk("bp_req",   32'(bus.imem_req),    32'd0);
        chk("bp_valid", 32'(bus.out_valid),   32'd1);
        bus.out_ready = 1'b1;
        collect("bp", 6, 32'd1, first);

        // Redirect to 0x20 with a full queue
        bus.out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h20;
        bus.out_ready   = 1'b1;
        #1;
        chk("rd_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk1);
        bus.redirect = 1'b0;
        #1;
        chk("rd_req",  32'(bus.imem_req),  32'd1);
        chk("rd_addr", 32'(bus.imem_addr), 32'h20);
        collect("rd", 2, 32'h21, first);
        chk("rd_lat", 32'(first), 32'(LAT));

        // Redirect mid-stream to 0x3FF: address wraps, npc does not
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h3FF;
        bus.out_ready   = 1'b0;
        #1;
        chk("wrap_rd_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk1);
        bus.redirect = 1'b0;
        #1;
        chk("wrap_addr0", 32'(bus.imem_addr), 32'h3FF);
        @(negedge clk1);
        #1;
        chk("wrap_addr1", 32'(bus.imem_addr), 32'h000);
        chk("wrap_req1",  32'(bus.imem_req),  32'd1);
        bus.out_ready = 1'b1;
        collect("wrap", 3, 32'h400, first);

        // HLT at address 2
        mem[2] = 32'hFC00_0000;
        bus.out_ready = 1'b1;
        do_reset();
        collect("hlt", 3, 32'd1, first);
        repeat (3) @(negedge clk1);
        #1;
        chk("hlt_halted", 32'(bus.halted),    32'd1);
        chk("hlt_reqs",   32'(req_cnt),       32'd3);
        chk("hlt_req",    32'(bus.imem_req),  32'd0);
        chk("hlt_valid",  32'(bus.out_valid), 32'd0);
        @(negedge clk1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h10;
        @(negedge clk1);
        bus.redirect = 1'b0;
        repeat (3) @(negedge clk1);
        #1;
        chk("hlt_rd_halted", 32'(bus.halted),   32'd1);
        chk("hlt_rd_reqs",   32'(req_cnt),      32'd3);
        chk("hlt_rd_req",    32'(bus.imem_req), 32'd0);
        mem[2] = {6'b000000, 26'd2};

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
